// File: rtl/ufp_req_issuer.sv
// Initiator side of the pipelined-cache upstream port. Client requests are
// accepted into a one-entry hold register that drives the cache directly;
// issued requests are tracked in a tag FIFO and in-order cache responses are
// returned to the client through a response FIFO. A credit counter bounds
// the requests between client accept and client response pop, so neither
// FIFO can overflow.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. On the client side the issuer drives req_ready and the client
// drives rsp_ready. On the cache side a request is presented whenever a
// mask is non-zero and is taken on the edge where ufp_stall is low.
module ufp_req_issuer #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_addr,
  input  logic [3:0]       req_rmask,
  input  logic [3:0]       req_wmask,
  input  logic [31:0]      req_wdata,
  input  logic [TAG_W-1:0] req_tag,
  output logic [31:0]      ufp_addr,
  output logic [3:0]       ufp_rmask,
  output logic [3:0]       ufp_wmask,
  output logic [31:0]      ufp_wdata,
  input  logic             ufp_stall,
  input  logic [31:0]      ufp_rdata,
  input  logic             ufp_resp,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_rdata,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             err_unexp
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  // Hold register: the request currently presented to the cache
  logic             hold_valid;
  logic [31:0]      hold_addr;
  logic [3:0]       hold_rmask;
  logic [3:0]       hold_wmask;
  logic [31:0]      hold_wdata;
  logic [TAG_W-1:0] hold_tag;

  // Credits: requests accepted but not yet popped by the client
  logic [CW-1:0] used;

  // Tag FIFO entry is {is_write, tag}
  logic [TAG_W:0]  tag_mem [DEPTH];
  logic [PW-1:0]   tag_wptr, tag_rptr;
  logic [CW-1:0]   tag_cnt;
  logic [TAG_W:0]  tag_head;
  logic            tag_empty;

  // Response FIFO entry is {rdata, tag}
  logic [31+TAG_W:0] rsp_mem [DEPTH];
  logic [PW-1:0]     rsp_wptr, rsp_rptr;
  logic [CW-1:0]     rsp_cnt;
  logic [31+TAG_W:0] rsp_wr_data;

  logic fire, accept, rsp_pop, rsp_push;

  assign fire      = hold_valid && !ufp_stall;
  assign req_ready = (!hold_valid || fire) && (used < DEPTH_C);
  assign accept    = req_valid && req_ready;
  assign rsp_pop   = rsp_valid && rsp_ready;
  assign tag_empty = (tag_cnt == '0);
  assign tag_head  = tag_mem[tag_rptr];
  assign rsp_push  = ufp_resp && !tag_empty;
  assign rsp_wr_data = {(tag_head[TAG_W] ? 32'h0 : ufp_rdata), tag_head[TAG_W-1:0]};

  assign ufp_addr  = hold_addr;
  assign ufp_wdata = hold_wdata;
  assign ufp_rmask = hold_valid ? hold_rmask : 4'h0;
  assign ufp_wmask = hold_valid ? hold_wmask : 4'h0;

  assign rsp_valid = (rsp_cnt != '0);
  assign {rsp_rdata, rsp_tag} = rsp_mem[rsp_rptr];

  // Load the hold register on accept, empty it when the cache takes it
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_valid <= 1'b0;
      hold_addr  <= '0;
      hold_rmask <= '0;
      hold_wmask <= '0;
      hold_wdata <= '0;
      hold_tag   <= '0;
    end else if (accept) begin
      hold_valid <= 1'b1;
      hold_addr  <= req_addr;
      hold_rmask <= req_rmask;
      hold_wmask <= req_wmask;
      hold_wdata <= req_wdata;
      hold_tag   <= req_tag;
    end else if (fire) begin
      hold_valid <= 1'b0;
    end
  end

  // Credit counter: +1 on accept, -1 on client pop, unchanged when both
  always_ff @(posedge clk) begin
    if (rst) begin
      used <= '0;
    end else begin
      case ({accept, rsp_pop})
        2'b10:   used <= used + 1'b1;
        2'b01:   used <= used - 1'b1;
        default: used <= used;
      endcase
    end
  end

  // Tag FIFO pointers: push on issue, pop on each cache response
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_wptr <= '0;
      tag_rptr <= '0;
      tag_cnt  <= '0;
    end else begin
      if (fire)     tag_wptr <= tag_wptr + 1'b1;
      if (rsp_push) tag_rptr <= tag_rptr + 1'b1;
      case ({fire, rsp_push})
        2'b10:   tag_cnt <= tag_cnt + 1'b1;
        2'b01:   tag_cnt <= tag_cnt - 1'b1;
        default: tag_cnt <= tag_cnt;
      endcase
    end
  end

  // Tag FIFO storage
  always_ff @(posedge clk) begin
    if (fire) tag_mem[tag_wptr] <= {(hold_wmask != 4'h0), hold_tag};
  end

  // Response FIFO pointers: push on matched cache response, pop on client take
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_wptr <= '0;
      rsp_rptr <= '0;
      rsp_cnt  <= '0;
    end else begin
      if (rsp_push) rsp_wptr <= rsp_wptr + 1'b1;
      if (rsp_pop)  rsp_rptr <= rsp_rptr + 1'b1;
      case ({rsp_push, rsp_pop})
        2'b10:   rsp_cnt <= rsp_cnt + 1'b1;
        2'b01:   rsp_cnt <= rsp_cnt - 1'b1;
        default: rsp_cnt <= rsp_cnt;
      endcase
    end
  end

  // Response FIFO storage
  always_ff @(posedge clk) begin
    if (rsp_push) rsp_mem[rsp_wptr] <= rsp_wr_data;
  end

  // Sticky flag for a cache response with nothing in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      err_unexp <= 1'b0;
    end else if (ufp_resp && tag_empty) begin
      err_unexp <= 1'b1;
    end
  end

  // An accepted request must be exactly one of read or write
  req_kind_legal: assert property (@(posedge clk) disable iff (rst)
    (req_valid && req_ready) |-> ((req_rmask != 4'h0) != (req_wmask != 4'h0)));

endmodule
